// File: rtl/fp_div_seq.sv
// Sequential single-precision divider: radix-2 restoring mantissa division,
// one quotient bit per clock, round half-up, overflow/underflow/div-by-zero flags.
module fp_div_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic        done,
  output logic [31:0] out,
  output logic        overflow,
  output logic        underflow,
  output logic        div_by_zero
);

  localparam int unsigned MANT_W = 24;
  localparam int unsigned R_W    = 25;
  localparam int unsigned Q_W    = 26;
  localparam int unsigned E_W    = 10;
  localparam int unsigned ITER   = 26;

  typedef enum logic [1:0] {IDLE, DIV, PACK} state_t;

  state_t            state, state_nxt;
  logic              sign, sign_nxt;
  logic [7:0]        ea, ea_nxt, eb, eb_nxt;
  logic              a_zero, a_zero_nxt, b_zero, b_zero_nxt;
  logic [MANT_W-1:0] mb, mb_nxt;
  logic [R_W-1:0]    r, r_nxt;
  logic [Q_W-1:0]    q, q_nxt;
  logic [4:0]        cnt, cnt_nxt;
  logic              busy_nxt, done_nxt, ov_nxt, un_nxt, dz_nxt;
  logic [31:0]       out_nxt;

  // One restoring step: the remainder stays below 2*Mb, so the low 24 bits hold the difference.
  logic              ge;
  logic [MANT_W-1:0] diff;
  assign ge   = r >= {1'b0, mb};
  assign diff = r[MANT_W-1:0] - mb;

  // Normalize on q[25], then round half-up; a fraction carry bumps the exponent.
  logic [E_W-1:0] e_raw, e_rnd;
  logic [22:0]    frac_pre;
  logic           guard;
  logic [23:0]    frac_sum;
  logic           e_big, e_small;

  assign frac_pre = q[25] ? q[24:2] : q[23:1];
  assign guard    = q[25] ? q[1] : q[0];
  assign frac_sum = {1'b0, frac_pre} + 24'(guard);
  assign e_raw    = {2'b00, ea} - {2'b00, eb} + (q[25] ? 10'd127 : 10'd126);
  assign e_rnd    = e_raw + 10'(frac_sum[23]);
  assign e_big    = $signed(e_rnd) >= 10'sd255;
  assign e_small  = $signed(e_rnd) <= 10'sd0;

  always_comb begin
    state_nxt  = state;
    sign_nxt   = sign;
    ea_nxt     = ea;
    eb_nxt     = eb;
    a_zero_nxt = a_zero;
    b_zero_nxt = b_zero;
    mb_nxt     = mb;
    r_nxt      = r;
    q_nxt      = q;
    cnt_nxt    = cnt;
    busy_nxt   = busy;
    done_nxt   = 1'b0;
    out_nxt    = out;
    ov_nxt     = overflow;
    un_nxt     = underflow;
    dz_nxt     = div_by_zero;
    case (state)
      IDLE: begin
        if (start) begin
          busy_nxt   = 1'b1;
          sign_nxt   = A[31] ^ B[31];
          ea_nxt     = A[30:23];
          eb_nxt     = B[30:23];
          a_zero_nxt = (A[30:23] == 8'd0);
          b_zero_nxt = (B[30:23] == 8'd0);
          mb_nxt     = {1'b1, B[22:0]};
          r_nxt      = {2'b01, A[22:0]};
          q_nxt      = '0;
          cnt_nxt    = '0;
          state_nxt  = ((A[30:23] == 8'd0) || (B[30:23] == 8'd0)) ? PACK : DIV;
        end
      end
      DIV: begin
        r_nxt   = ge ? {diff, 1'b0} : {r[MANT_W-1:0], 1'b0};
        q_nxt   = {q[Q_W-2:0], ge};
        cnt_nxt = cnt + 5'd1;
        if (cnt == 5'(ITER - 1)) state_nxt = PACK;
      end
      PACK: begin
        done_nxt  = 1'b1;
        busy_nxt  = 1'b0;
        ov_nxt    = 1'b0;
        un_nxt    = 1'b0;
        dz_nxt    = 1'b0;
        state_nxt = IDLE;
        if (a_zero && b_zero) begin
          out_nxt = 32'h7FC0_0000;
          dz_nxt  = 1'b1;
        end else if (b_zero) begin
          out_nxt = {sign, 8'hFF, 23'h0};
          dz_nxt  = 1'b1;
        end else if (a_zero) begin
          out_nxt = {sign, 31'h0};
        end else if (e_big) begin
          out_nxt = {sign, 8'hFF, 23'h0};
          ov_nxt  = 1'b1;
        end else if (e_small) begin
          out_nxt = {sign, 31'h0};
          un_nxt  = 1'b1;
        end else begin
          out_nxt = {sign, e_rnd[7:0], frac_sum[22:0]};
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      sign        <= 1'b0;
      ea          <= '0;
      eb          <= '0;
      a_zero      <= 1'b0;
      b_zero      <= 1'b0;
      mb          <= '0;
      r           <= '0;
      q           <= '0;
      cnt         <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      out         <= '0;
      overflow    <= 1'b0;
      underflow   <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      state       <= state_nxt;
      sign        <= sign_nxt;
      ea          <= ea_nxt;
      eb          <= eb_nxt;
      a_zero      <= a_zero_nxt;
      b_zero      <= b_zero_nxt;
      mb          <= mb_nxt;
      r           <= r_nxt;
      q           <= q_nxt;
      cnt         <= cnt_nxt;
      busy        <= busy_nxt;
      done        <= done_nxt;
      out         <= out_nxt;
      overflow    <= ov_nxt;
      underflow   <= un_nxt;
      div_by_zero <= dz_nxt;
    end
  end

endmodule

// File: tb/tb_fp_div_seq.sv
// Directed self-checking bench for fp_div_seq: results, flags, latency,
// back-to-back starts, ignored starts while busy, and mid-operation reset.
module tb_fp_div_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [31:0] A = '0;
  logic [31:0] B = '0;
  logic        busy, done, overflow, underflow, div_by_zero;
  logic [31:0] out;

  int checks = 0;
  int errors = 0;
  int lat, busy_cyc, done_seen;

  fp_div_seq dut (
    .clk(clk), .rst(rst), .start(start), .A(A), .B(B),
    .busy(busy), .done(done), .out(out),
    .overflow(overflow), .underflow(underflow), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] flags();
    return {29'd0, overflow, underflow, div_by_zero};
  endfunction

  // Called at a negedge; returns at the negedge of the done cycle (or on timeout).
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input bit noise,
                        output int n_lat, output int n_busy);
    A = a; B = b; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0; A = ~a; B = ~b;
    check("done_drop", {31'd0, done}, 32'd0);
    n_lat = 0; n_busy = 0;
    while (done !== 1'b1 && n_lat < 60) begin
      if (busy === 1'b1) n_busy++;
      if (noise && (n_lat == 4 || n_lat == 15)) begin
        start = 1'b1; A = 32'h3F80_0000; B = 32'h4040_0000;
      end else begin
        start = 1'b0;
      end
      @(posedge clk);
      n_lat++;
      @(negedge clk);
    end
    start = 1'b0;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_out", out, 32'h0);
    check("rst_flags", flags(), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // 6.0 / 2.0
    run_op(32'h40C0_0000, 32'h4000_0000, 1'b0, lat, busy_cyc);
    check("div6_2_out", out, 32'h4040_0000);
    check("div6_2_flags", flags(), 32'd0);
    check("div6_2_lat", 32'(lat), 32'd27);
    check("div6_2_busy_cyc", 32'(busy_cyc), 32'd27);
    check("div6_2_busy_at_done", {31'd0, busy}, 32'd0);
    @(negedge clk);
    check("done_pulse_width", {31'd0, done}, 32'd0);
    check("out_held", out, 32'h4040_0000);

    // 1.0 / 3.0 then -6.0 / 2.0 back-to-back
    run_op(32'h3F80_0000, 32'h4040_0000, 1'b0, lat, busy_cyc);
    check("div1_3_out", out, 32'h3EAA_AAAB);
    check("div1_3_lat", 32'(lat), 32'd27);
    run_op(32'hC0C0_0000, 32'h4000_0000, 1'b0, lat, busy_cyc);
    check("b2b_out", out, 32'hC040_0000);
    check("b2b_lat", 32'(lat), 32'd27);
    @(negedge clk);

    // Overflow then underflow
    run_op(32'h7F00_0000, 32'h3E80_0000, 1'b0, lat, busy_cyc);
    check("ovf_out", out, 32'h7F80_0000);
    check("ovf_flags", flags(), 32'd4);
    @(negedge clk);
    run_op(32'h0080_0000, 32'h4000_0000, 1'b0, lat, busy_cyc);
    check("unf_out", out, 32'h0000_0000);
    check("unf_flags", flags(), 32'd2);
    @(negedge clk);

    // Zero operands
    run_op(32'hC000_0000, 32'h0000_0000, 1'b0, lat, busy_cyc);
    check("dz_out", out, 32'hFF80_0000);
    check("dz_flags", flags(), 32'd1);
    check("dz_lat", 32'(lat), 32'd1);
    @(negedge clk);
    run_op(32'h0000_0000, 32'h0000_0000, 1'b0, lat, busy_cyc);
    check("zz_out", out, 32'h7FC0_0000);
    check("zz_flags", flags(), 32'd1);
    @(negedge clk);
    run_op(32'h0000_0000, 32'h4000_0000, 1'b0, lat, busy_cyc);
    check("z2_out", out, 32'h0000_0000);
    check("z2_flags", flags(), 32'd0);
    check("z2_lat", 32'(lat), 32'd1);
    @(negedge clk);

    // Start pulses while busy are ignored
    run_op(32'h40C0_0000, 32'h4000_0000, 1'b1, lat, busy_cyc);
    check("noise_out", out, 32'h4040_0000);
    check("noise_lat", 32'(lat), 32'd27);
    @(negedge clk);
    check("noise_no_restart", {31'd0, busy}, 32'd0);

    // Reset at iteration 10
    A = 32'h40C0_0000; B = 32'h4000_0000; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    check("pre_rst_busy", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    #1;
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_out", out, 32'h0);
    check("mid_rst_flags", flags(), 32'd0);
    done_seen = 0;
    repeat (3) begin
      @(negedge clk);
      if (done === 1'b1) done_seen++;
    end
    rst = 1'b0;
    repeat (30) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) done_seen++;
    end
    check("mid_rst_no_done", 32'(done_seen), 32'd0);
    run_op(32'h3F80_0000, 32'h4040_0000, 1'b0, lat, busy_cyc);
    check("after_rst_out", out, 32'h3EAA_AAAB);
    check("after_rst_lat", 32'(lat), 32'd27);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fp_div_seq.md
# fp_div_seq

Sequential single-precision floating-point divider, the inverse operation of the floating-point ALU's combinational multiplier. It computes A/B on 32-bit IEEE-754-layout operands with a start/busy/done handshake. It uses a radix-2 restoring mantissa divider that produces one quotient bit per clock. Results are normalized and rounded half-up, and the block raises the same overflow and underflow flags as the multiplier, plus a divide-by-zero flag.

## Interface
- No parameters; format fixed at sign[31], exponent[30:23] (bias 127), fraction[22:0].
- clk  in  1  single clock; all state changes on its rising edge.
- rst  in  1  reset, asynchronous and active-high.
- start  in  1  request; sampled only while busy=0.
- A  in  32  dividend; captured on accepted start.
- B  in  32  divisor; captured on accepted start.
- busy  out  1  high from the edge after acceptance until the edge that raises done.
- done  out  1  one-cycle pulse; out and flags valid from this cycle.
- out  out  32  quotient; held until the next completion.
- overflow  out  1  result exponent ≥ 255; held with out.
- underflow  out  1  result exponent ≤ 0; held with out.
- div_by_zero  out  1  B is zero; held with out.

## Operation
- Operand classification:
  - An operand is zero when its bits [30:0] have exponent 0; nonzero fractions with exponent 0 are flushed to zero.
  - Exponent 255 gets no special treatment and is processed numerically.
- Sign = A[31] ^ B[31].
- Hidden bit is 1 for nonzero operands: Ma = {1, A[22:0]}, Mb = {1, B[22:0]}.
- States:
  - IDLE: on start, capture operands and compute sign.
  - Special case (A zero or B zero): go to PACK.
  - Otherwise: load R = {0, Ma} (25 bits) and go to DIV.
- DIV, 26 iterations with a 5-bit counter:
  - If R ≥ Mb: q bit = 1, R = (R − Mb) << 1.
  - Else: q bit = 0, R = R << 1.
  - The q bit shifts into a 26-bit q, MSB first.
  - After the 26th iteration go to PACK. Result: q = floor(Ma·2^25 / Mb), with q ∈ [2^24, 2^26).
- PACK, normalize:
  - If q[25]: frac = q[24:2], guard = q[1], e = Ea − Eb + 127.
  - Else: frac = q[23:1], guard = q[0], e = Ea − Eb + 126.
  - e is 10-bit signed.
- PACK, round:
  - frac += guard.
  - On carry out of frac: frac = 0, e += 1.
- PACK, priority (first match wins):
  1. A zero and B zero: out = 32'h7FC00000, div_by_zero = 1.
  2. B zero: out = {sign, 8'hFF, 23'h0}, div_by_zero = 1.
  3. A zero: out = {sign, 31'h0}.
  4. e ≥ 255: out = {sign, 8'hFF, 23'h0}, overflow = 1.
  5. e ≤ 0: out = {sign, 31'h0}, underflow = 1.
  6. Otherwise: out = {sign, e[7:0], frac}.
- Flag updates: flags not set by the matching row are cleared on the same edge.
- PACK exit: register out and flags, pulse done, return to IDLE.

## Timing
- Reset values: state = IDLE; busy = 0, done = 0, out = 32'h0, overflow = underflow = div_by_zero = 0; counter, R and q cleared.
- Acceptance: start is accepted at rising edge T0 when busy = 0; busy = 1 from T0.
- Normal latency: DIV occupies edges T0+1 … T0+26, PACK at T0+27. done = 1 and busy = 0 during the cycle after T0+27.
- Special latency: PACK at T0+1, so done = 1 during the cycle after T0+1.
- start while busy = 1: ignored; captured operands unaffected.
- Back-to-back: start asserted in the done cycle is accepted (busy = 0 then); done drops on the next edge.
- Operand changes on A and B after acceptance have no effect.
- Reset mid-operation: immediate return to reset values, with no done pulse and no stale result.

## Test plan
- 6.0/2.0: A = 40C00000, B = 40000000 → out = 40400000, no flags, done exactly 27 cycles after the accepting edge, busy high for those cycles.
- 1.0/3.0: A = 3F800000, B = 40400000 → out = 3EAAAAAB (round up via guard). Then −6.0/2.0 back-to-back, with start in the done cycle → C0400000.
- Overflow: A = 7F000000, B = 3E800000 → out = 7F800000, overflow = 1. Next, underflow: A = 00800000, B = 40000000 → out = 00000000, underflow = 1, overflow cleared.
- Divide by zero: A = C0000000, B = 00000000 → out = FF800000, div_by_zero = 1, done 1 cycle after acceptance. 0/0 → 7FC00000. 0/B with B = 40000000 → 00000000, no flags.
- Reset and busy rules:
  - Assert rst at iteration 10 of 6.0/2.0 → all outputs zero at once, no done; a fresh start then completes normally.
  - start pulses during busy are ignored, and the result matches the first operands.
